// File: rtl/ccc_seq_pkg.sv
// Shared types for the CCC reconfiguration sequencer: FSM state encoding,
// divider widths and the packed CCC setting record.
package ccc_seq_pkg;

  localparam int FINDIV_W = 7;
  localparam int FBDIV_W  = 7;
  localparam int OADIV_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GATE      = 3'd1,
    ST_APPLY     = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_STABLE    = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAIL      = 3'd6
  } ccc_state_t;

  typedef struct packed {
    logic [FINDIV_W-1:0] findiv;
    logic [FBDIV_W-1:0]  fbdiv;
    logic [OADIV_W-1:0]  oadiv;
    logic                bypassa;
  } ccc_cfg_t;

  function automatic ccc_cfg_t make_cfg(input logic [FINDIV_W-1:0] findiv,
                                        input logic [FBDIV_W-1:0]  fbdiv,
                                        input logic [OADIV_W-1:0]  oadiv,
                                        input logic                bypassa);
    ccc_cfg_t c;
    c.findiv  = findiv;
    c.fbdiv   = fbdiv;
    c.oadiv   = oadiv;
    c.bypassa = bypassa;
    return c;
  endfunction

endpackage

// File: rtl/ccc_lock_qual.sv
// LOCK qualifier: 2-flop synchronizer for the raw CCC lock plus a counter of
// consecutive synced-high cycles while enabled; lock_stable flags the last one.
module ccc_lock_qual #(
  parameter int STABLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock,
  input  logic en,
  output logic lock_s,
  output logic lock_stable
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic          lock_m;
  logic [SW-1:0] run_cnt;

  // Counter restarts whenever qualification is not running or the lock drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_m  <= 1'b0;
      lock_s  <= 1'b0;
      run_cnt <= '0;
    end else begin
      lock_m  <= lock;
      lock_s  <= lock_m;
      run_cnt <= (en && lock_s && !lock_stable) ? run_cnt + 1'b1 : '0;
    end
  end

  assign lock_stable = en && lock_s && (run_cnt == SW'(STABLE_CYCLES - 1));

endmodule

// File: rtl/ccc_reconfig_sequencer.sv
// Sequences a run-time CCC divider/bypass change: gate consumers, apply + PLL reset,
// qualify lock with timeout, fall back to bypass on failure. Option macro: CCC_AUTO_RELOCK_EN.
module ccc_reconfig_sequencer
  import ccc_seq_pkg::*;
#(
  parameter int                  GATE_CYCLES    = 4,
  parameter int                  PLL_RST_CYCLES = 8,
  parameter int                  LOCK_TIMEOUT   = 4096,
  parameter int                  STABLE_CYCLES  = 64,
  parameter logic [FINDIV_W-1:0] RST_FINDIV     = 7'd6,
  parameter logic [FBDIV_W-1:0]  RST_FBDIV      = 7'd6,
  parameter logic [OADIV_W-1:0]  RST_OADIV      = 5'd0
) (
  input  logic                FAB_CLK,
  input  logic                RESET_N,
  input  logic                CFG_REQ,
  input  logic [FINDIV_W-1:0] CFG_FINDIV,
  input  logic [FBDIV_W-1:0]  CFG_FBDIV,
  input  logic [OADIV_W-1:0]  CFG_OADIV,
  input  logic                CFG_BYPASSA,
  output logic                CFG_ACK,
  output logic                CFG_BUSY,
  output logic                CFG_ERR,
  output logic [FINDIV_W-1:0] FINDIV,
  output logic [FBDIV_W-1:0]  FBDIV,
  output logic [OADIV_W-1:0]  OADIV,
  output logic                BYPASSA,
  output logic                PLL_RESET,
  input  logic                LOCK,
  output logic                LOCKED,
  output logic                CLK_GATE_EN,
  output logic                LOCK_LOST,
  output logic [2:0]          state_dbg
);

  // Handshake: CFG_REQ is a level sampled only in IDLE; the IDLE->GATE edge accepts it.
  // CFG_ACK pulses once in DONE/FAIL; the requester must lower CFG_REQ by then or a new sequence starts.

  localparam int       CNT_MAX = (GATE_CYCLES > PLL_RST_CYCLES) ? GATE_CYCLES : PLL_RST_CYCLES;
  localparam int       CNT_W   = $clog2(CNT_MAX + 1);
  localparam int       TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam ccc_cfg_t RST_CFG = make_cfg(RST_FINDIV, RST_FBDIV, RST_OADIV, 1'b1);

  ccc_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  to_cnt;
  ccc_cfg_t         shadow, cfg_q;
  logic             locked_q, err_q, lock_lost_q;
  logic             lock_s, lock_stable, lost_det;

  ccc_lock_qual #(.STABLE_CYCLES(STABLE_CYCLES)) u_lock_qual (
    .clk        (FAB_CLK),
    .rst_n      (RESET_N),
    .lock       (LOCK),
    .en         (state == ST_STABLE),
    .lock_s     (lock_s),
    .lock_stable(lock_stable)
  );

  assign lost_det = (state == ST_IDLE) && locked_q && !lock_s;

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (CFG_REQ) next_state = ST_GATE;
`ifdef CCC_AUTO_RELOCK_EN
        else if (lost_det && !cfg_q.bypassa) next_state = ST_GATE;
`endif
      end
      ST_GATE:
        if (cnt == CNT_W'(GATE_CYCLES - 1)) next_state = ST_APPLY;
      ST_APPLY:
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) next_state = shadow.bypassa ? ST_DONE : ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)                                     next_state = ST_STABLE;
        else if (to_cnt >= TO_W'(LOCK_TIMEOUT - 1))     next_state = ST_FAIL;
      end
      ST_STABLE: begin
        if (!lock_s)          next_state = ST_WAIT_LOCK;
        else if (lock_stable) next_state = ST_DONE;
      end
      ST_DONE, ST_FAIL: next_state = ST_IDLE;
      default:          next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    CFG_ACK     = 1'b0;
    CFG_BUSY    = 1'b0;
    CLK_GATE_EN = 1'b1;
    PLL_RESET   = 1'b0;
    case (state)
      ST_GATE, ST_WAIT_LOCK, ST_STABLE: begin
        CFG_BUSY    = 1'b1;
        CLK_GATE_EN = 1'b0;
      end
      ST_APPLY: begin
        CFG_BUSY    = 1'b1;
        CLK_GATE_EN = 1'b0;
        PLL_RESET   = 1'b1;
      end
      ST_DONE, ST_FAIL: CFG_ACK = 1'b1;
      default: ;
    endcase
  end

  // The timeout count survives STABLE->WAIT_LOCK bounces and saturates, so it never wraps.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      cnt         <= '0;
      to_cnt      <= '0;
      shadow      <= RST_CFG;
      cfg_q       <= RST_CFG;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      if ((state == ST_GATE || state == ST_APPLY) && next_state == state) cnt <= cnt + 1'b1;
      else                                                                cnt <= '0;
      if (state == ST_APPLY)                                              to_cnt <= '0;
      else if (state == ST_WAIT_LOCK && to_cnt != TO_W'(LOCK_TIMEOUT))    to_cnt <= to_cnt + 1'b1;
      lock_lost_q <= lost_det;
      if (lost_det) locked_q <= 1'b0;
      if (state == ST_IDLE && next_state == ST_GATE) begin
        if (CFG_REQ) begin
          shadow <= make_cfg(CFG_FINDIV, CFG_FBDIV, CFG_OADIV, CFG_BYPASSA);
          err_q  <= 1'b0;
        end else begin
          shadow <= cfg_q;
        end
      end
      if (state == ST_GATE && next_state == ST_APPLY) begin
        cfg_q    <= shadow;
        locked_q <= 1'b0;
      end
      if (state == ST_STABLE && next_state == ST_DONE) locked_q <= 1'b1;
      if (next_state == ST_FAIL) begin
        cfg_q.bypassa <= 1'b1;
        err_q         <= 1'b1;
        locked_q      <= 1'b0;
      end
    end
  end

  assign FINDIV    = cfg_q.findiv;
  assign FBDIV     = cfg_q.fbdiv;
  assign OADIV     = cfg_q.oadiv;
  assign BYPASSA   = cfg_q.bypassa;
  assign LOCKED    = locked_q;
  assign CFG_ERR   = err_q;
  assign LOCK_LOST = lock_lost_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_ccc_reconfig_sequencer.sv
// Self-checking bench for ccc_reconfig_sequencer (GATE=4, PLL_RST=8, TIMEOUT=64, STABLE=16);
// LOCK waveforms are generated per sequence and outcomes predicted by a cycle-level reference model.
module tb_ccc_reconfig_sequencer;
  import ccc_seq_pkg::*;

  localparam int G = 4;
  localparam int P = 8;
  localparam int T = 64;
  localparam int N = 16;
  localparam int NEVER = 1 << 20;

  logic       FAB_CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CFG_REQ = 1'b0;
  logic [6:0] CFG_FINDIV = '0;
  logic [6:0] CFG_FBDIV = '0;
  logic [4:0] CFG_OADIV = '0;
  logic       CFG_BYPASSA = 1'b0;
  logic       LOCK = 1'b0;
  logic       CFG_ACK, CFG_BUSY, CFG_ERR, BYPASSA, PLL_RESET, LOCKED, CLK_GATE_EN, LOCK_LOST;
  logic [6:0] FINDIV, FBDIV;
  logic [4:0] OADIV;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_fin, exp_fb;
  logic [4:0] exp_oa;
  logic       exp_byp;

  ccc_reconfig_sequencer #(
    .GATE_CYCLES(G), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T), .STABLE_CYCLES(N)
  ) dut (
    .FAB_CLK(FAB_CLK), .RESET_N(RESET_N), .CFG_REQ(CFG_REQ),
    .CFG_FINDIV(CFG_FINDIV), .CFG_FBDIV(CFG_FBDIV), .CFG_OADIV(CFG_OADIV), .CFG_BYPASSA(CFG_BYPASSA),
    .CFG_ACK(CFG_ACK), .CFG_BUSY(CFG_BUSY), .CFG_ERR(CFG_ERR),
    .FINDIV(FINDIV), .FBDIV(FBDIV), .OADIV(OADIV), .BYPASSA(BYPASSA),
    .PLL_RESET(PLL_RESET), .LOCK(LOCK), .LOCKED(LOCKED), .CLK_GATE_EN(CLK_GATE_EN),
    .LOCK_LOST(LOCK_LOST), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge FAB_CLK);
    #1;
  endtask

  // Raw LOCK level in cycle k of a sequence (cycle 0 = acceptance cycle).
  function automatic bit lw(input int k, input int rise, input int glitch);
    return (k >= rise) && (k != glitch);
  endfunction

  // Reference model. Synced lock in cycle t equals raw lock of cycle t-2. Lock search starts
  // once gating (G) and the reset window (P) are over. While searching, each cycle costs one
  // unit of the T-cycle budget; a synced-high cycle starts a run, success needs that cycle plus
  // N further consecutive highs; running out of budget on a low cycle is failure. ACK follows next cycle.
  function automatic void model(input bit byp, input int rise, input int glitch,
                                output int k_ack, output bit ok);
    int waits;
    int run;
    bit ls;
    waits = 0;
    run = 0;
    ok = 1'b0;
    k_ack = 0;
    if (byp) begin
      k_ack = G + P + 1;
      ok = 1'b1;
      return;
    end
    for (int t = G + P + 1; t < 100000; t++) begin
      ls = lw(t - 2, rise, glitch);
      if (run == 0) begin
        if (ls) run = 1;
        else if (waits >= T - 1) begin
          k_ack = t + 1;
          ok = 1'b0;
          break;
        end
        if (waits < T) waits++;
      end else if (ls) begin
        run++;
        if (run == N + 1) begin
          k_ack = t + 1;
          ok = 1'b1;
          break;
        end
      end else begin
        run = 0;
      end
    end
  endfunction

  // Drives one sequence from the current cycle (cycle 0) and checks every cycle until 3 past ACK.
  task automatic run_seq(input bit do_req, input int rise, input int glitch,
                         input int req_pulse, input int lost_k);
    int  k_ack;
    int  rp;
    bit  ok;
    bit  in_seq;
    model(exp_byp, rise, glitch, k_ack, ok);
    rp = (req_pulse == 0) ? $urandom_range(1, k_ack - 1) : req_pulse;
    if (do_req) begin
      CFG_FINDIV = exp_fin;
      CFG_FBDIV = exp_fb;
      CFG_OADIV = exp_oa;
      CFG_BYPASSA = exp_byp;
      CFG_REQ = 1'b1;
    end
    LOCK = lw(0, rise, glitch);
    for (int k = 1; k <= k_ack + 3; k++) begin
      step();
      CFG_REQ = (k == rp);
      CFG_BYPASSA = $urandom_range(0, 1);
      LOCK = lw(k, rise, glitch);
      in_seq = (k >= 1) && (k < k_ack);
      checks++;
      if (CFG_ACK !== (k == k_ack)) begin
        failures++;
        $display("FAIL cfg_ack k=%0d got=%0b exp=%0b (ack expected at %0d)", k, CFG_ACK, (k == k_ack), k_ack);
      end
      checks++;
      if (CFG_BUSY !== in_seq) begin
        failures++;
        $display("FAIL cfg_busy k=%0d got=%0b exp=%0b", k, CFG_BUSY, in_seq);
      end
      checks++;
      if (CLK_GATE_EN !== !in_seq) begin
        failures++;
        $display("FAIL clk_gate_en k=%0d got=%0b exp=%0b", k, CLK_GATE_EN, !in_seq);
      end
      checks++;
      if (PLL_RESET !== (k >= G + 1 && k <= G + P)) begin
        failures++;
        $display("FAIL pll_reset k=%0d got=%0b exp=%0b", k, PLL_RESET, (k >= G + 1 && k <= G + P));
      end
      checks++;
      if (LOCK_LOST !== (k == lost_k)) begin
        failures++;
        $display("FAIL lock_lost k=%0d got=%0b exp=%0b", k, LOCK_LOST, (k == lost_k));
      end
      if (k == k_ack) begin
        checks++;
        if ({FINDIV, FBDIV, OADIV} !== {exp_fin, exp_fb, exp_oa}) begin
          failures++;
          $display("FAIL settings got=%0d/%0d/%0d exp=%0d/%0d/%0d", FINDIV, FBDIV, OADIV, exp_fin, exp_fb, exp_oa);
        end
        checks++;
        if (BYPASSA !== (exp_byp | !ok)) begin
          failures++;
          $display("FAIL bypassa got=%0b exp=%0b", BYPASSA, (exp_byp | !ok));
        end
        checks++;
        if (CFG_ERR !== !ok) begin
          failures++;
          $display("FAIL cfg_err got=%0b exp=%0b", CFG_ERR, !ok);
        end
        checks++;
        if (LOCKED !== (ok && !exp_byp)) begin
          failures++;
          $display("FAIL locked got=%0b exp=%0b", LOCKED, (ok && !exp_byp));
        end
      end
      if (k > k_ack) begin
        checks++;
        if (state_dbg !== ST_IDLE) begin
          failures++;
          $display("FAIL idle_after_ack k=%0d got=%0d exp=%0d", k, state_dbg, ST_IDLE);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({FINDIV, FBDIV, OADIV} !== {7'd6, 7'd6, 5'd0}) begin
      failures++;
      $display("FAIL %s_dividers got=%0d/%0d/%0d exp=6/6/0", tag, FINDIV, FBDIV, OADIV);
    end
    checks++;
    if ({BYPASSA, CLK_GATE_EN, LOCKED, PLL_RESET} !== 4'b1100) begin
      failures++;
      $display("FAIL %s_ctrl got=%b exp=1100 (bypassa,gate_en,locked,pll_reset)", tag,
               {BYPASSA, CLK_GATE_EN, LOCKED, PLL_RESET});
    end
    checks++;
    if ({CFG_ACK, CFG_BUSY, CFG_ERR, LOCK_LOST} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_status got=%b exp=0000 (ack,busy,err,lock_lost)", tag,
               {CFG_ACK, CFG_BUSY, CFG_ERR, LOCK_LOST});
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL %s_state got=%0d exp=%0d", tag, state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) step();
    RESET_N = 1'b1;
    check_reset_values("reset");
  endtask

  task automatic test_lock_success();
    exp_fin = 7'd3; exp_fb = 7'd12; exp_oa = 5'($urandom_range(0, 31)); exp_byp = 1'b0;
    // PLL_RESET falls at cycle G+P+1; LOCK rises 20 cycles later.
    run_seq(1'b1, G + P + 1 + 20, -1, -1, -1);
  endtask

  task automatic test_lock_timeout();
    exp_fin = 7'd3; exp_fb = 7'd12; exp_oa = 5'($urandom_range(0, 31)); exp_byp = 1'b0;
    run_seq(1'b1, NEVER, -1, -1, -1);
  endtask

  task automatic test_glitch_and_ignored_req();
    int rise;
    exp_fin = 7'd40; exp_fb = 7'd77; exp_oa = 5'd9; exp_byp = 1'b0;
    // Synced lock first high at rise+2 (WAIT_LOCK), STABLE from rise+3; cycle 10 of STABLE is rise+12.
    rise = G + P + 1 + 20;
    run_seq(1'b1, rise, rise + 10, 20, -1);
  endtask

  task automatic test_bypass();
    exp_fin = 7'd100; exp_fb = 7'd5; exp_oa = 5'd31; exp_byp = 1'b1;
    // ACK lands in the 14th cycle counting the acceptance cycle: 1 + G + P + 1.
    run_seq(1'b1, NEVER, -1, -1, -1);
  endtask

  task automatic test_lock_lost();
    exp_fin = 7'd9; exp_fb = 7'd20; exp_oa = 5'd2; exp_byp = 1'b0;
    run_seq(1'b1, 30, -1, -1, -1);
    step();
    LOCK = 1'b0;
    step();
    step();
    checks++;
    if ({LOCK_LOST, LOCKED} !== 2'b01) begin
      failures++;
      $display("FAIL lost_before got=%b exp=01 (lock_lost,locked)", {LOCK_LOST, LOCKED});
    end
`ifdef CCC_AUTO_RELOCK_EN
    run_seq(1'b0, 25, -1, -1, 1);
`else
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({LOCK_LOST, LOCKED, CLK_GATE_EN, CFG_BUSY} !== {(i == 1), 3'b010}) begin
        failures++;
        $display("FAIL lost_idle i=%0d got=%b exp=%b (lock_lost,locked,gate_en,busy)", i,
                 {LOCK_LOST, LOCKED, CLK_GATE_EN, CFG_BUSY}, {(i == 1), 3'b010});
      end
      checks++;
      if (state_dbg !== ST_IDLE) begin
        failures++;
        $display("FAIL lost_state i=%0d got=%0d exp=%0d", i, state_dbg, ST_IDLE);
      end
    end
`endif
  endtask

  task automatic test_back_to_back_random();
    int rise;
    int glitch;
    for (int n = 0; n < 8; n++) begin
      exp_fin = 7'($urandom_range(0, 127));
      exp_fb = 7'($urandom_range(0, 127));
      exp_oa = 5'($urandom_range(0, 31));
      exp_byp = ($urandom_range(0, 3) == 0);
      rise = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 70);
      glitch = ($urandom_range(0, 1) == 1) ? rise + $urandom_range(2, 12) : -1;
      run_seq(1'b1, rise, glitch, 0, -1);
    end
  endtask

  task automatic test_reset_mid();
    exp_fin = 7'd50; exp_fb = 7'd60; exp_oa = 5'd17; exp_byp = 1'b0;
    CFG_FINDIV = exp_fin; CFG_FBDIV = exp_fb; CFG_OADIV = exp_oa; CFG_BYPASSA = 1'b0;
    CFG_REQ = 1'b1;
    LOCK = 1'b0;
    step();
    CFG_REQ = 1'b0;
    repeat (G + 2) step();
    checks++;
    if ({PLL_RESET, FINDIV} !== {1'b1, exp_fin}) begin
      failures++;
      $display("FAIL mid_apply got=%b/%0d exp=1/%0d (pll_reset,findiv)", PLL_RESET, FINDIV, exp_fin);
    end
    RESET_N = 1'b0;
    step();
    check_reset_values("mid_reset");
    RESET_N = 1'b1;
    step();
    check_reset_values("mid_release");
  endtask

  initial begin
    test_reset();
    test_lock_success();
    test_lock_timeout();
    test_glitch_and_ignored_req();
    test_bypass();
    test_lock_lost();
    test_back_to_back_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
